// File: rtl/mole_spawner_pkg.sv
// rtl/mole_spawner_pkg.sv - shared constants, level encodings and FSM state type for the mole spawner
package mole_spawner_pkg;

   localparam int NUM_LEDS  = 18;
   localparam int LED_IDX_W = 5;

   localparam logic [1:0] LVL_EASY = 2'b00;
   localparam logic [1:0] LVL_MED  = 2'b01;
   localparam logic [1:0] LVL_HARD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_PICK,
      ST_ISSUE
   } state_e;

   // Galois form of x^16 + x^14 + x^13 + x^11, shifting right
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
   endfunction

endpackage

// File: rtl/mole_spawner_lfsr16.sv
// rtl/mole_spawner_lfsr16.sv - 16-bit Galois LFSR, one step per cycle while advance_i is high
module mole_spawner_lfsr16
   import mole_spawner_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        advance_i,
   input  logic [15:0] seed_i,
   output logic [15:0] q_o
);

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   assign lfsr_d = lfsr_step(lfsr_q);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= seed_i;
      end else if (advance_i) begin
         lfsr_q <= lfsr_d;
      end
   end

   assign q_o = lfsr_q;

endmodule

// File: rtl/mole_spawner.sv
// rtl/mole_spawner.sv - periodic pseudo-random LED request generator feeding the LED/switch controller
module mole_spawner
   import mole_spawner_pkg::*;
#(
   parameter int          PERIOD_L0 = 50_000_000,
   parameter int          PERIOD_L1 = 25_000_000,
   parameter int          PERIOD_L2 = 12_500_000,
   parameter int          MAX_TRIES = 8,
   parameter logic [15:0] SEED      = 16'hACE1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   input  logic [1:0]           level_i,
   input  logic [NUM_LEDS-1:0]  active_leds_i,
   output logic [LED_IDX_W-1:0] led_index_o,
   output logic                 led_request_o,
   output logic                 spawn_skipped_o
);

   localparam int CNT_W = $clog2(PERIOD_L0 + 1);
   localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);
   // indices at or above NUM_LEDS are treated as permanently occupied
   localparam logic [31:0] OUT_OF_RANGE = ~((32'd1 << NUM_LEDS) - 32'd1);

   function automatic logic [CNT_W-1:0] period_of(input logic [1:0] lvl);
      case (lvl)
         LVL_EASY: return CNT_W'(PERIOD_L0);
         LVL_MED:  return CNT_W'(PERIOD_L1);
         default:  return CNT_W'(PERIOD_L2);
      endcase
   endfunction

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [TRY_W-1:0]       tries_q;
   logic [LED_IDX_W-1:0]   led_index_q;
   logic                   led_request_q;
   logic                   spawn_skipped_q;

   logic [15:0]            lfsr_q;
   logic                   lfsr_adv;
   logic [LED_IDX_W-1:0]   cand;
   logic [31:0]            occupied;
   logic                   cand_free;
   logic                   all_busy;
   logic [CNT_W-1:0]       reload;
   logic                   unused_lfsr_hi;

   assign lfsr_adv       = (state_q != ST_IDLE);
   assign cand           = lfsr_q[LED_IDX_W-1:0];
   assign unused_lfsr_hi = ^lfsr_q[15:LED_IDX_W];
   assign occupied       = 32'(active_leds_i) | OUT_OF_RANGE;
   assign cand_free      = ~occupied[cand];
   assign all_busy       = &active_leds_i;
   // PICK and ISSUE count toward the interval, so slots recur every period+1 cycles
   assign reload         = period_of(level_i) - CNT_W'(1);

   mole_spawner_lfsr16 u_lfsr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .advance_i (lfsr_adv),
      .seed_i    (SEED),
      .q_o       (lfsr_q)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= ST_IDLE;
         cnt_q           <= '0;
         tries_q         <= '0;
         led_index_q     <= '0;
         led_request_q   <= 1'b0;
         spawn_skipped_q <= 1'b0;
      end else begin
         led_request_q   <= 1'b0;
         spawn_skipped_q <= 1'b0;
         if (!enable_i) begin
            state_q <= ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  cnt_q   <= period_of(level_i);
                  state_q <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (cnt_q == '0) begin
                     tries_q <= '0;
                     state_q <= ST_PICK;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
               ST_PICK: begin
                  if (all_busy || (!cand_free && tries_q == LAST_TRY)) begin
                     spawn_skipped_q <= 1'b1;
                     cnt_q           <= reload;
                     state_q         <= ST_WAIT;
                  end else if (cand_free) begin
                     led_index_q   <= cand;
                     led_request_q <= 1'b1;
                     cnt_q         <= reload;
                     state_q       <= ST_ISSUE;
                  end else begin
                     tries_q <= tries_q + TRY_W'(1);
                  end
               end
               ST_ISSUE: begin
                  cnt_q   <= cnt_q - CNT_W'(1);
                  state_q <= ST_WAIT;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign led_index_o     = led_index_q;
   assign led_request_o   = led_request_q;
   assign spawn_skipped_o = spawn_skipped_q;

endmodule
